fetch: RTL

//  Instruction fetch stage directly upstream of instruction decode. Reads the opcode byte and
//  0-2 operand bytes from a registered-read memory, determines instruction length from the

---
 rtl/fetch.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch.sv
// fetch: instruction fetch stage with reset-vector load, variable-length decode and redirect
module fetch #(
  parameter logic        USE_VECTOR = 1'b1,
  parameter logic [15:0] RST_VECTOR = 16'hFFFC,
  parameter logic [15:0] RESET_PC   = 16'h0200
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr,
  output logic [15:0] operand,
  output logic [15:0] instr_pc,
  output logic [1:0]  instr_len
);
  typedef enum logic [2:0] {VECL, VECH, VHI, OPC, OPD, OP1, OP2, HOLD} state_t;
  state_t st, nxt;
  logic [15:0] pc, addr, res_opr;
  logic [7:0] op_q, lo_q, res_op;
  logic [1:0] len_q, l, res_len;
  logic rd, done;
  function automatic logic [1:0] len_of(input logic [7:0] o);
    len_of = (o[1:0] == 2'b11 || o == 8'h00 || o == 8'h40 || o == 8'h60) ? 2'd1 :
             o == 8'h20 ? 2'd3 :
             (o[1:0] != 2'b01 && o[3:2] == 2'b10) ? 2'd1 :
             (o[3:2] == 2'b11 || (o[1:0] == 2'b01 && o[4:2] == 3'b110)) ? 2'd3 : 2'd2;
  endfunction
  assign l = len_of(mem_rdata);
  always_comb begin
    nxt = st;
    rd = 1'b0;
    addr = pc;
    case (st)
      VECL: begin rd = 1'b1; addr = RST_VECTOR; nxt = VECH; end
      VECH: begin rd = 1'b1; addr = RST_VECTOR + 16'd1; nxt = VHI; end
      VHI:  nxt = OPC;
      OPC:  begin rd = 1'b1; nxt = OPD; end
      OPD:  begin rd = l != 2'd1; addr = pc + 16'd1; nxt = l == 2'd1 ? HOLD : OP1; end
      OP1:  begin rd = len_q == 2'd3; addr = pc + 16'd2; nxt = len_q == 2'd3 ? OP2 : HOLD; end
      OP2:  nxt = HOLD;
      HOLD: begin rd = instr_ready; addr = pc + {14'd0, instr_len}; nxt = instr_ready ? OPD : HOLD; end
    endcase
    if (redirect_valid) begin
      rd = 1'b0;
      nxt = OPC;
    end
  end
  // the read strobe is held off while reset is asserted even though the state is VECL
  assign mem_rd = rd & rst_n;
  assign mem_addr = mem_rd ? addr : 16'h0000;
  assign done = (st == OPD && l == 2'd1) || (st == OP1 && len_q == 2'd2) || st == OP2;
  assign res_op = st == OPD ? mem_rdata : op_q;
  assign res_opr = st == OP2 ? {mem_rdata, lo_q} : st == OP1 ? {8'h00, mem_rdata} : 16'h0000;
  assign res_len = st == OPD ? 2'd1 : st == OP1 ? 2'd2 : 2'd3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= USE_VECTOR ? VECL : OPC;
      pc <= USE_VECTOR ? 16'h0000 : RESET_PC;
      op_q <= 8'h00;
      lo_q <= 8'h00;
      len_q <= 2'd0;
      instr_valid <= 1'b0;
      instr <= 8'h00;
      operand <= 16'h0000;
      instr_pc <= 16'h0000;
      instr_len <= 2'd0;
    end else begin
      st <= nxt;
      if (redirect_valid) begin
        pc <= redirect_pc;
        instr_valid <= 1'b0;
      end else begin
        if (st == VECH || st == OP1) lo_q <= mem_rdata;
        if (st == VHI) pc <= {mem_rdata, lo_q};
        if (st == OPD) begin
          op_q <= mem_rdata;
          len_q <= l;
        end
        if (st == HOLD && instr_ready) begin
          pc <= pc + {14'd0, instr_len};
          instr_valid <= 1'b0;
        end
        if (done) begin
          instr_valid <= 1'b1;
          instr <= res_op;
          operand <= res_opr;
          instr_pc <= pc;
          instr_len <= res_len;
        end
      end
    end
  end
endmodule
